// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, talks to instruction memory over a req/ready handshake, absorbs
// one word of ID back-pressure in a skid buffer, and drains an outstanding
// memory transaction after a redirect before fetching from the new target.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_sa,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm,
    output logic [25:0] id_target,
    output logic [1:0]  id_itype
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic [31:0] drain_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_plus4;
    logic        id_accept;
    logic        unused_redirect_lsbs;

    // Instruction class from the primary opcode: R, J or everything else (I).
    function automatic logic [1:0] itype_of(input logic [5:0] opcode);
        if (opcode == 6'd0)
            return 2'b00;
        else if (opcode == 6'd2 || opcode == 6'd3)
            return 2'b10;
        else
            return 2'b01;
    endfunction

    assign pc_plus4             = pc + 32'd4;
    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    // ID takes a new word when it is not stalled or currently holds nothing.
    assign id_accept            = !stall || !id_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Next-state logic; redirect outranks stall in every state.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (redirect)
                    state_nxt = imem_ready ? FETCH : DRAIN;
                else if (imem_ready && !id_accept)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (redirect || !stall)
                    state_nxt = FETCH;
            end
            DRAIN: begin
                if (imem_ready)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Memory request outputs; DRAIN keeps presenting the abandoned address.
    always_comb begin
        imem_req  = rst_n && (state != HOLD);
        imem_addr = (state == DRAIN) ? drain_addr : pc;
    end

    // PC, IF/ID register, skid buffer and drain address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            id_valid      <= 1'b0;
            id_instr      <= 32'd0;
            id_pc_plus4   <= 32'd0;
            skid_instr    <= 32'd0;
            skid_pc_plus4 <= 32'd0;
            drain_addr    <= 32'd0;
        end else if (redirect) begin
            id_valid <= 1'b0;
            pc       <= redirect_tgt;
            if (state == FETCH && !imem_ready)
                drain_addr <= pc;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc_plus4;
                        if (id_accept) begin
                            id_valid    <= 1'b1;
                            id_instr    <= imem_rdata;
                            id_pc_plus4 <= pc_plus4;
                        end else begin
                            skid_instr    <= imem_rdata;
                            skid_pc_plus4 <= pc_plus4;
                        end
                    end else if (id_accept) begin
                        id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid    <= 1'b1;
                        id_instr    <= skid_instr;
                        id_pc_plus4 <= skid_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_opcode = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_sa     = id_instr[10:6];
    assign id_funct  = id_instr[5:0];
    assign id_imm    = id_instr[15:0];
    assign id_target = id_instr[25:0];
    assign id_itype  = itype_of(id_instr[31:26]);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenario tasks plus a scoreboard of
// fetched words that is checked whenever ID consumes an instruction.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd, id_sa;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [25:0] id_target;
    logic [1:0]  id_itype;

    logic        unused_d2_req;
    logic [31:0] d2_imem_addr;
    logic [31:0] d2_imem_rdata;
    logic        d2_id_valid;
    logic [31:0] d2_id_instr;
    logic [31:0] d2_id_pc_plus4;
    logic [5:0]  unused_d2_opcode;
    logic [4:0]  unused_d2_rs, unused_d2_rt, unused_d2_rd, unused_d2_sa;
    logic [5:0]  unused_d2_funct;
    logic [15:0] unused_d2_imm;
    logic [25:0] unused_d2_target;
    logic [1:0]  unused_d2_itype;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         sb_e;
    sb_t         snap;
    logic [31:0] exp_pc;
    bit          draining;
    logic [31:0] old_addr;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h012A_4020;
            32'h0000_0044: return 32'h0800_0010;
            32'h0000_0048: return 32'h8D09_0004;
            default:       return {8'h24, a[23:0]};
        endcase
    endfunction

    assign imem_rdata    = mem_word(imem_addr);
    assign d2_imem_rdata = mem_word(d2_imem_addr);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sa(id_sa),
        .id_funct(id_funct), .id_imm(id_imm), .id_target(id_target),
        .id_itype(id_itype)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(unused_d2_req), .imem_addr(d2_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(d2_imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(d2_id_valid),
        .id_instr(d2_id_instr), .id_pc_plus4(d2_id_pc_plus4), .id_opcode(unused_d2_opcode),
        .id_rs(unused_d2_rs), .id_rt(unused_d2_rt), .id_rd(unused_d2_rd), .id_sa(unused_d2_sa),
        .id_funct(unused_d2_funct), .id_imm(unused_d2_imm), .id_target(unused_d2_target),
        .id_itype(unused_d2_itype)
    );

    // Scoreboard: predicts the coming edge from inputs and handshake, pops on consume.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_pc   = 32'h0000_0000;
            draining = 1'b0;
        end else begin
            if (id_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: id_valid=1 id_instr=%h but nothing expected", id_instr);
                end else begin
                    sb_e = sb_q.pop_front();
                    n_checks++;
                    if (id_instr !== sb_e.instr) begin
                        n_fail++;
                        $display("FAIL sb_instr: got %h expected %h", id_instr, sb_e.instr);
                    end
                    n_checks++;
                    if (id_pc_plus4 !== sb_e.pc4) begin
                        n_fail++;
                        $display("FAIL sb_pc4: got %h expected %h", id_pc_plus4, sb_e.pc4);
                    end
                end
            end
            if (redirect) begin
                sb_q.delete();
                if (draining)
                    draining = !imem_ready;
                else
                    draining = imem_req && !imem_ready;
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (draining) begin
                if (imem_ready)
                    draining = 1'b0;
            end else if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL sb_addr: got %h expected %h", imem_addr, exp_pc);
                end
                if (imem_ready) begin
                    sb_e.instr = mem_word(exp_pc);
                    sb_e.pc4   = exp_pc + 32'd4;
                    sb_q.push_back(sb_e);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        n_checks++; if (id_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
        n_checks++; if (id_pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", id_pc_plus4); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        n_checks++; if (id_itype !== 2'b00) begin n_fail++; $display("FAIL reset_itype: got %b expected 00", id_itype); end
        n_checks++; if (d2_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_addr_wrap: got %h expected fffffffc", d2_imem_addr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (imem_addr !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", k, imem_addr, 32'(k * 4)); end
            if (k > 0) begin
                n_checks++;
                if (id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected 1", k, id_valid); end
                n_checks++;
                if (id_pc_plus4 !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_pc4%0d: got %h expected %h", k, id_pc_plus4, 32'(k * 4)); end
            end
        end
    endtask

    task automatic test_decode();
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick(); redirect = 1'b0;
        @(negedge clk);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL dec_bubble: got %b expected 0", id_valid); end
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL dec_addr: got %h expected 40", imem_addr); end
        @(negedge clk);
        n_checks++; if (id_opcode !== 6'd0) begin n_fail++; $display("FAIL add_opcode: got %h expected 0", id_opcode); end
        n_checks++; if (id_rs !== 5'd9) begin n_fail++; $display("FAIL add_rs: got %0d expected 9", id_rs); end
        n_checks++; if (id_rt !== 5'd10) begin n_fail++; $display("FAIL add_rt: got %0d expected 10", id_rt); end
        n_checks++; if (id_rd !== 5'd8) begin n_fail++; $display("FAIL add_rd: got %0d expected 8", id_rd); end
        n_checks++; if (id_sa !== 5'd0) begin n_fail++; $display("FAIL add_sa: got %0d expected 0", id_sa); end
        n_checks++; if (id_funct !== 6'h20) begin n_fail++; $display("FAIL add_funct: got %h expected 20", id_funct); end
        n_checks++; if (id_itype !== 2'b00) begin n_fail++; $display("FAIL add_itype: got %b expected 00", id_itype); end
        @(negedge clk);
        n_checks++; if (id_itype !== 2'b10) begin n_fail++; $display("FAIL j_itype: got %b expected 10", id_itype); end
        n_checks++; if (id_target !== 26'h10) begin n_fail++; $display("FAIL j_target: got %h expected 10", id_target); end
        @(negedge clk);
        n_checks++; if (id_itype !== 2'b01) begin n_fail++; $display("FAIL lw_itype: got %b expected 01", id_itype); end
        n_checks++; if (id_imm !== 16'h0004) begin n_fail++; $display("FAIL lw_imm: got %h expected 0004", id_imm); end
        n_checks++; if (id_opcode !== 6'h23) begin n_fail++; $display("FAIL lw_opcode: got %h expected 23", id_opcode); end
    endtask

    task automatic test_stall();
        tick(); stall = 1'b1;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL stall_snap: got empty queue expected a displayed instruction");
            snap.instr = 32'd0; snap.pc4 = 32'd0;
        end else begin
            snap = sb_q[0];
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b expected 1", i, id_valid); end
            n_checks++; if (id_instr !== snap.instr) begin n_fail++; $display("FAIL stall_instr%0d: got %h expected %h", i, id_instr, snap.instr); end
            n_checks++; if (id_pc_plus4 !== snap.pc4) begin n_fail++; $display("FAIL stall_pc4%0d: got %h expected %h", i, id_pc_plus4, snap.pc4); end
            if (i > 0) begin
                n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %b expected 0", i, imem_req); end
            end
        end
        tick(); stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (id_pc_plus4 !== snap.pc4 + 32'd4) begin n_fail++; $display("FAIL skid_pc4: got %h expected %h", id_pc_plus4, snap.pc4 + 32'd4); end
        n_checks++; if (id_instr !== mem_word(snap.pc4)) begin n_fail++; $display("FAIL skid_instr: got %h expected %h", id_instr, mem_word(snap.pc4)); end
        n_checks++; if (imem_addr !== snap.pc4 + 32'd4) begin n_fail++; $display("FAIL skid_addr: got %h expected %h", imem_addr, snap.pc4 + 32'd4); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL skid_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_redirect_stall();
        tick(); stall = 1'b1;
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick(); redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b expected 0", id_valid); end
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rs_addr: got %h expected 100", imem_addr); end
        @(negedge clk);
        n_checks++; if (id_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL rs_pc4: got %h expected 104", id_pc_plus4); end
    endtask

    task automatic test_redirect_drain();
        tick(); old_addr = exp_pc; imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick(); redirect_pc = 32'h0000_0304;
        @(negedge clk);
        n_checks++; if (imem_addr !== old_addr) begin n_fail++; $display("FAIL drain_addr1: got %h expected %h", imem_addr, old_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_req: got %b expected 1", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid1: got %b expected 0", id_valid); end
        tick(); redirect = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_addr !== old_addr) begin n_fail++; $display("FAIL drain_addr2: got %h expected %h", imem_addr, old_addr); end
        tick(); imem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_addr !== old_addr) begin n_fail++; $display("FAIL drain_addr3: got %h expected %h", imem_addr, old_addr); end
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h304) begin n_fail++; $display("FAIL drain_target: got %h expected 304", imem_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid2: got %b expected 0", id_valid); end
        @(negedge clk);
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid3: got %b expected 1", id_valid); end
        n_checks++; if (id_pc_plus4 !== 32'h308) begin n_fail++; $display("FAIL drain_pc4: got %h expected 308", id_pc_plus4); end
    endtask

    task automatic test_reset_mid_stall();
        tick(); stall = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b expected 0", imem_req); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL mid_addr: got %h expected 0", imem_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", id_valid); end
        n_checks++; if (id_instr !== 32'd0) begin n_fail++; $display("FAIL mid_instr: got %h expected 0", id_instr); end
        n_checks++; if (id_pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL mid_pc4: got %h expected 0", id_pc_plus4); end
        n_checks++; if (id_opcode !== 6'd0) begin n_fail++; $display("FAIL mid_opcode: got %h expected 0", id_opcode); end
        @(posedge clk);
        #1 stall = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        n_checks++; if (d2_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffffffc", d2_imem_addr); end
        @(negedge clk);
        n_checks++; if (d2_id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b expected 1", d2_id_valid); end
        n_checks++; if (d2_id_pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", d2_id_pc_plus4); end
        n_checks++; if (d2_imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0", d2_imem_addr); end
        n_checks++; if (d2_id_instr !== 32'h24FF_FFFC) begin n_fail++; $display("FAIL wrap_instr: got %h expected 24fffffc", d2_id_instr); end
        @(negedge clk);
        n_checks++; if (d2_id_pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL wrap_pc4b: got %h expected 4", d2_id_pc_plus4); end
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_sequential();
        test_decode();
        test_stall();
        test_redirect_stall();
        test_redirect_drain();
        test_reset_mid_stall();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It produces the decoded instruction fields that the ID-stage control unit consumes: opcode, rs, rt, rd, sa, funct, immediate, jump target and instruction type.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Honours stall back-pressure from ID and PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  instruction memory request valid
- imem_addr  output  32  byte address of requested word (bits [1:0] always 0)
- imem_ready  input  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid when imem_req & imem_ready
- stall  input  1  ID cannot accept a new instruction; hold IF/ID outputs
- redirect  input  1  branch/jump taken; discard fetched work, restart at redirect_pc
- redirect_pc  input  32  new PC (bits [1:0] ignored, forced 0)
- id_valid  output  1  IF/ID register holds a valid instruction
- id_instr  output  32  raw instruction word
- id_pc_plus4  output  32  PC of the instruction + 4
- id_opcode  output  6  instr[31:26]
- id_rs  output  5  instr[25:21]
- id_rt  output  5  instr[20:16]
- id_rd  output  5  instr[15:11]
- id_sa  output  5  instr[10:6]
- id_funct  output  6  instr[5:0]
- id_imm  output  16  instr[15:0]
- id_target  output  26  instr[25:0]
- id_itype  output  2  00=R (opcode 0), 10=J (opcode 2 or 3), 01=I (all other opcodes); 11 never driven

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=FETCH.
  - All id_* outputs 0 and id_valid=0.
  - imem_req=0 while in reset; the skid buffer is cleared.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_addr and imem_req stay stable until imem_ready=1.
  - On imem_req & imem_ready, with ID able to accept (stall=0 or id_valid=0):
    - IF/ID loads imem_rdata and all fields.
    - id_pc_plus4=pc+4; id_valid=1; pc<=pc+4.
    - Throughput is 1 instruction/cycle and latency is 1 edge.
  - On imem_ready while stall=1 and id_valid=1:
    - Word goes to the skid buffer with its pc+4; pc<=pc+4; go to HOLD.
  - No imem_ready and no stall (or id_valid=0): id_valid<=0 (bubble).
  - No imem_ready while stall=1 and id_valid=1: IF/ID holds.
- HOLD:
  - imem_req=0; IF/ID outputs held unchanged.
  - When stall=0: IF/ID loads from the skid buffer, id_valid=1, return to FETCH.
- Stall: while stall=1 and id_valid=1, every id_* output is bit-stable.
- Redirect (highest priority, overrides stall):
  - Next edge: id_valid<=0; skid buffer discarded; pc<={redirect_pc[31:2],2'b00}.
  - In FETCH with imem_req=1 and imem_ready=0: a transaction is outstanding, so go to DRAIN. The old imem_addr is kept until imem_ready, and the returned data is discarded.
  - In FETCH with imem_ready=1 the same cycle: the returned word is discarded; next state FETCH at the new pc.
  - In HOLD: next state FETCH at the new pc.
- DRAIN:
  - imem_req=1 at the old address; id_valid=0.
  - On imem_ready, drop the data and go to FETCH using the redirected pc.
  - A second redirect during DRAIN overwrites the pending pc.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Mid-operation reset: immediate return to reset values; any outstanding memory transaction is abandoned.

Test Plan:
- Reset then imem_ready=1 constant, memory returns addr-derived words → imem_addr 0,4,8,…; id_valid high from first edge; id_pc_plus4 = 4,8,12.
- Fetch 32'h012A4020 (add $8,$9,$10) → opcode 0, rs 9, rt 10, rd 8, sa 0, funct 6'h20, itype 00. Fetch 32'h08000010 (j) → itype 10, target 26'h10. Fetch 32'h8D090004 (lw) → itype 01, imm 16'h0004.
- stall=1 for 3 cycles while ready=1 → id_* frozen; one extra word skid-buffered; imem_req=0. After release, the buffered word appears next edge with no PC gap or duplicate.
- redirect=1, redirect_pc=32'h0000_0103 while stall=1 → id_valid=0 next edge; next imem_addr=32'h0000_0100.
- redirect while imem_ready=0 for 2 cycles → imem_addr held at the old value until ready. That data is never presented (id_valid stays 0); the next request is to the redirect target.
- RESET_PC=32'hFFFF_FFFC → first id_pc_plus4=0, second fetch address 0; rst_n pulled low mid-stall → all outputs 0 immediately.
